// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

    localparam int SS_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The overflow signal only exists when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, diff, borrow_out, overflow);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, diff, borrow_out, overflow);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, diff, borrow_out);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_fs.sv
// 1-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Optional: SERIAL_SUB_OVERFLOW_EN adds a signed overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic             bor, d, bor_nxt;
    logic             take, last;

    // Operands are only taken in IDLE; in_ready is high there by construction.
    assign take = (state == IDLE) && bus.in_valid;
    assign last = (cnt == CW'(WIDTH - 1));

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bor),
        .d    (d),
        .bout (bor_nxt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial datapath: operand shift regs, result shifts in at MSB, borrow chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
        end else if (take) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            bor  <= 1'b0;
            cnt  <= '0;
        end else if (state == BUSY) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            res  <= {d, res[WIDTH-1:1]};
            bor  <= bor_nxt;
            cnt  <= cnt + 1'b1;
        end
    end

    assign bus.diff       = res;
    assign bus.borrow_out = bor;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_sign, b_sign;

    // Operand signs are captured at accept since the shift regs drain during BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
        end else if (take) begin
            a_sign <= bus.a[WIDTH-1];
            b_sign <= bus.b[WIDTH-1];
        end
    end

    assign bus.overflow = (a_sign != b_sign) && (res[WIDTH-1] != a_sign);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bor;
        logic         ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand pair at a negedge, accept on the next posedge,
    // then wait (bounded) for out_valid and check the latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ordy, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = ordy;
        check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) lat = k;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
    endtask

    initial begin
        vecs[0] = '{a: 8'h35, b: 8'h12, diff: 8'h23, bor: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bor: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bor: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bor: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'hFF, b: 8'h7F, diff: 8'h80, bor: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h80, diff: 8'h80, bor: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bor: 1'b0, ovf: 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        #12;
        check("reset in_ready",   32'(bus.in_ready),   32'd1);
        check("reset out_valid",  32'(bus.out_valid),  32'd0);
        check("reset diff",       32'(bus.diff),       32'd0);
        check("reset borrow_out", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("reset overflow",   32'(bus.overflow),   32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors, consumer always ready
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].a, vecs[i].b, 1'b1, tag);
            check({tag, " diff"},      32'(bus.diff),       32'(vecs[i].diff));
            check({tag, " borrow"},    32'(bus.borrow_out), 32'(vecs[i].bor));
            check({tag, " in_ready"},  32'(bus.in_ready),   32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
            check({tag, " overflow"},  32'(bus.overflow),   32'(vecs[i].ovf));
`endif
            @(posedge clk);
            #1;
            check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        end

        // Back-pressure: result holds for 5 cycles, new operands ignored
        run_op(8'hA5, 8'hA5, 1'b0, "bp");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'h55;
        bus.b        = 8'h11;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp out_valid held", 32'(bus.out_valid),  32'd1);
            check("bp diff held",      32'(bus.diff),       32'h00);
            check("bp borrow held",    32'(bus.borrow_out), 32'd0);
            check("bp in_ready low",   32'(bus.in_ready),   32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check("bp release in_ready",  32'(bus.in_ready),  32'd1);

        // Reset three cycles into BUSY aborts asynchronously
        @(negedge clk);
        bus.a        = 8'hFF;
        bus.b        = 8'h00;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready",  32'(bus.in_ready),  32'd1);
        check("abort diff",      32'(bus.diff),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h10, 8'h01, 1'b1, "post-abort");
        check("post-abort diff",   32'(bus.diff),       32'h0F);
        check("post-abort borrow", 32'(bus.borrow_out), 32'd0);
        @(posedge clk);

        // Back-to-back: in_valid held high, second op accepted only after handshake
        @(negedge clk);
        bus.a         = 8'h35;
        bus.b         = 8'h12;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 8'h09;
        bus.b = 8'h03;
        repeat (7) begin
            @(posedge clk);
            #1;
            check("b2b busy in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        check("b2b first out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b first diff",      32'(bus.diff),      32'h23);
        @(posedge clk);
        #1;
        check("b2b idle out_valid",  32'(bus.out_valid), 32'd0);
        check("b2b idle in_ready",   32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        check("b2b second accepted", 32'(bus.in_ready),  32'd0);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("b2b second early",    32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("b2b second out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b second diff",      32'(bus.diff),      32'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
